// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Moore-style control FSM for a multicycle MIPS datapath (R-type, lw, sw,
// beq, j, jal). The state register drives every datapath select, enable and
// write strobe; outputs decode from the state register alone, except
// illegal_op/instr_done in DECODE, which also look at the opcode.
//
// Optional feature macro: MC_MEM_READY_EN
//   When defined, the mem_ready port exists and FETCH, MEMRD and MEMWR wait
//   for it. When undefined, memory is treated as always ready.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset (state -> RST)
//   opcode[5:0]    IR[31:26], sampled only in DECODE and MEMADR
//   mem_ready      memory handshake (MC_MEM_READY_EN only)
//   pc_write, pc_write_cond, pc_src[1:0], i_or_d, mem_read, mem_write,
//   ir_write, reg_dst, mem_to_reg, reg_write, jal, alu_src_a,
//   alu_src_b[1:0], alu_op[1:0]    datapath controls
//   illegal_op     unsupported opcode seen in DECODE
//   instr_done     high in the final cycle of each instruction
//   state[3:0]     current state encoding (debug)

module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
`ifdef MC_MEM_READY_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       jal,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11
    } state_t;

    state_t state_reg;
    logic   mem_ok;

`ifdef MC_MEM_READY_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign state = state_reg;

    // Next-state logic. Memory states hold until the memory answers;
    // encodings 12-15 (default branch) recover to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_RST;
        end else begin
            case (state_reg)
                S_RST:    state_reg <= S_FETCH;
                S_FETCH:  state_reg <= mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:      state_reg <= S_EXEC;
                        OP_LW, OP_SW:  state_reg <= S_MEMADR;
                        OP_BEQ:        state_reg <= S_BEQ;
                        OP_J:          state_reg <= S_JUMP;
                        OP_JAL:        state_reg <= S_JAL;
                        default:       state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_reg <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_reg <= mem_ok ? S_MEMWB : S_MEMRD;
                S_MEMWR:  state_reg <= mem_ok ? S_FETCH : S_MEMWR;
                S_EXEC:   state_reg <= S_ALUWB;
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    // Output decode from the state register.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        jal           = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                // Only the cycle the memory answers may load PC and IR,
                // so each fetch advances the PC exactly once.
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!(opcode inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW})) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                // A stalled store is not finished until memory accepts it.
                instr_done = mem_ok;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_src        = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                jal        = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: table-driven directed vectors,
// hand-written reset/async-abort (and mem_ready stall) sequences, and a
// randomized instruction stream checked against a per-instruction model.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
`ifdef MC_MEM_READY_EN
    logic       mem_ready;
`endif
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, jal, alu_src_a, illegal_op, instr_done;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;
    logic [18:0] outv;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode),
`ifdef MC_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .jal(jal), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
        .instr_done(instr_done), .state(state)
    );

    assign outv = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, jal, alu_src_a,
                   alu_src_b, alu_op, illegal_op, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [18:0] mk(input logic pw, input logic pwc, input logic [1:0] ps,
                                       input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic j, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop);
        return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, j, asa, asb, aop, 2'b00};
    endfunction

    function automatic bit supported(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h23, 6'h2B};
    endfunction

    // Expected outputs per state, straight from the state/output listing.
    logic [18:0] st_out [0:11];

    function automatic logic [18:0] expected(input logic [3:0] st, input logic [5:0] op);
        logic [18:0] e;
        e = st_out[st];
        if (st == 4'd2 && !supported(op)) e = e | 19'b11;
        return e;
    endfunction

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic [3:0] st;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] op, input logic [3:0] st);
        vec_t v;
        v.r = r; v.op = op; v.st = st;
        vecs.push_back(v);
    endtask

    // Random stream: per-instruction expected state sequences and latencies.
    logic [5:0] kind_op [0:6];
    int         kind_lat [0:6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_out[0]  = mk(0,0,2'd0,0,0,0,0,0,0,0,0,0,2'd0,2'd0);
        st_out[1]  = mk(1,0,2'd0,0,1,0,1,0,0,0,0,0,2'd1,2'd0);
        st_out[2]  = mk(0,0,2'd0,0,0,0,0,0,0,0,0,0,2'd3,2'd0);
        st_out[3]  = mk(0,0,2'd0,0,0,0,0,0,0,0,0,1,2'd2,2'd0);
        st_out[4]  = mk(0,0,2'd0,1,1,0,0,0,0,0,0,0,2'd0,2'd0);
        st_out[5]  = mk(0,0,2'd0,0,0,0,0,0,1,1,0,0,2'd0,2'd0) | 19'b1;
        st_out[6]  = mk(0,0,2'd0,1,0,1,0,0,0,0,0,0,2'd0,2'd0) | 19'b1;
        st_out[7]  = mk(0,0,2'd0,0,0,0,0,0,0,0,0,1,2'd0,2'd2);
        st_out[8]  = mk(0,0,2'd0,0,0,0,0,1,0,1,0,0,2'd0,2'd0) | 19'b1;
        st_out[9]  = mk(0,1,2'd1,0,0,0,0,0,0,0,0,1,2'd0,2'd1) | 19'b1;
        st_out[10] = mk(1,0,2'd2,0,0,0,0,0,0,0,0,0,2'd0,2'd0) | 19'b1;
        st_out[11] = mk(1,0,2'd2,0,0,0,0,0,0,1,1,0,2'd0,2'd0) | 19'b1;

        kind_op  = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h03, 6'h3F};
        kind_lat = '{5, 4, 4, 3, 3, 3, 2};

        rst = 1'b1;
        opcode = 6'h23;
`ifdef MC_MEM_READY_EN
        mem_ready = 1'b1;
`endif

        // ---------------- directed table ----------------
        add(1, 6'h23, 0); add(1, 6'h23, 0); add(1, 6'h23, 0);
        add(0, 6'h23, 0);
        add(0, 6'h23, 1); add(0, 6'h23, 2); add(0, 6'h23, 3); add(0, 6'h23, 4); add(0, 6'h23, 5);
        add(0, 6'h3F, 1); add(0, 6'h2B, 2); add(0, 6'h2B, 3); add(0, 6'h01, 6);
        add(0, 6'h3F, 1); add(0, 6'h00, 2); add(0, 6'h23, 7); add(0, 6'h2B, 8);
        add(0, 6'h04, 1); add(0, 6'h04, 2); add(0, 6'h23, 9);
        add(0, 6'h03, 1); add(0, 6'h03, 2); add(0, 6'h00, 11);
        add(0, 6'h02, 1); add(0, 6'h02, 2); add(0, 6'h2B, 10);
        add(0, 6'h3F, 1); add(0, 6'h3F, 2); add(0, 6'h3F, 1);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst = vecs[i].r;
            opcode = vecs[i].op;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_outs", i), 32'(outv), 32'(expected(vecs[i].st, vecs[i].op)));
            $display("vec %0d: rst=%0b op=%h state=%0d outs=%h", i, vecs[i].r, vecs[i].op, state, outv);
        end

        // ---------------- async reset during MEMRD ----------------
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; opcode = 6'h23;
        for (int c = 0; c < 4; c++) @(posedge clk);
        @(negedge clk);
        check("abort_pre_state", 32'(state), 32'd4);
        check("abort_pre_mem_read", 32'(mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_mem_read", 32'(mem_read), 32'd0);
        check("abort_outs", 32'(outv), 32'd0);
        $display("abort: state=%0d mem_read=%0b", state, mem_read);
        @(posedge clk); #1; rst = 1'b0;

        // ---------------- random instruction stream ----------------
        for (int n = 0; n < 300; n++) begin
            int k;
            int done_at;
            logic [5:0] op;
            logic [3:0] seq[$];
            k = $urandom_range(0, 6);
            op = kind_op[k];
            if (k == 6) begin
                op = 6'($urandom_range(0, 63));
                while (supported(op)) op = 6'($urandom_range(0, 63));
            end
            seq = '{4'd1, 4'd2};
            case (k)
                0: seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
                1: seq = '{4'd1, 4'd2, 4'd3, 4'd6};
                2: seq = '{4'd1, 4'd2, 4'd7, 4'd8};
                3: seq = '{4'd1, 4'd2, 4'd9};
                4: seq = '{4'd1, 4'd2, 4'd10};
                5: seq = '{4'd1, 4'd2, 4'd11};
                default: ;
            endcase
            done_at = 0;
            foreach (seq[c]) begin
                logic [5:0] drv;
                @(posedge clk); #1;
                // Opcode matters only in DECODE and (for loads/stores) MEMADR;
                // every other cycle gets junk that must be ignored.
                if (c == 1 || (c == 2 && k <= 1)) drv = op;
                else drv = 6'($urandom_range(0, 63));
                opcode = drv;
                @(negedge clk);
                check($sformatf("rnd%0d_c%0d_state", n, c), 32'(state), 32'(seq[c]));
                check($sformatf("rnd%0d_c%0d_outs", n, c), 32'(outv), 32'(expected(seq[c], drv)));
                if (instr_done && done_at == 0) done_at = c + 1;
            end
            check($sformatf("rnd%0d_latency", n), 32'(done_at), 32'(kind_lat[k]));
            $display("rnd %0d: op=%h latency=%0d", n, op, done_at);
        end

`ifdef MC_MEM_READY_EN
        // ---------------- mem_ready stall in FETCH ----------------
        begin
            int pulses;
            pulses = 0;
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check($sformatf("stall%0d_state", c), 32'(state), 32'd1);
                check($sformatf("stall%0d_pc_write", c), 32'(pc_write), 32'd0);
                check($sformatf("stall%0d_mem_read", c), 32'(mem_read), 32'd1);
                if (pc_write) pulses++;
            end
            @(posedge clk); #1; mem_ready = 1'b1;
            @(negedge clk);
            check("stall_ready_state", 32'(state), 32'd1);
            check("stall_ready_pc_write", 32'(pc_write), 32'd1);
            check("stall_ready_ir_write", 32'(ir_write), 32'd1);
            if (pc_write) pulses++;
            @(posedge clk); #1; mem_ready = 1'b0;
            @(negedge clk);
            check("stall_decode_state", 32'(state), 32'd2);
            if (pc_write) pulses++;
            check("stall_pc_pulses", 32'(pulses), 32'd1);
            $display("stall: pc_write pulses=%0d", pulses);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style finite state machine that sequences the multicycle MIPS datapath over several clock cycles per instruction, instead of decoding every control in one cycle. It sits beside the shared ALU, the unified instruction/data memory, the instruction register and the register file. It reads the opcode held in the instruction register and drives every datapath select, enable and write strobe. Supported opcodes: R-type, lw, sw, beq, j and jal.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]; valid from the DECODE state onward
- mem_ready  input  1  memory handshake; this port exists only with MC_MEM_READY_EN
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by ALU zero (beq)
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  1 = rd is the write register, 0 = rt
- mem_to_reg  output  1  1 = MDR is the write data, 0 = ALUOut
- reg_write  output  1  register file write enable
- jal  output  1  forces the write register to $31 and the write data to PC
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct field
- illegal_op  output  1  unsupported opcode detected in DECODE
- instr_done  output  1  high in the final cycle of each instruction
- state  output  4  current state encoding, for debug

## Operation
State encoding and the outputs each state asserts. Every output not listed is 0.
- 0 RST: all outputs 0; always goes to FETCH
- 1 FETCH: mem_read, ir_write, pc_write; alu_src_b=01
- 2 DECODE: alu_src_b=11, so the branch target is computed into ALUOut
- 3 MEMADR: alu_src_a=1, alu_src_b=10
- 4 MEMRD: mem_read, i_or_d
- 5 MEMWB: reg_write, mem_to_reg, instr_done
- 6 MEMWR: mem_write, i_or_d, instr_done
- 7 EXEC: alu_src_a=1, alu_op=10
- 8 ALUWB: reg_dst, reg_write, instr_done
- 9 BEQ: alu_src_a=1, alu_op=01, pc_src=01, pc_write_cond, instr_done
- 10 JUMP: pc_src=10, pc_write, instr_done
- 11 JAL: pc_src=10, pc_write, reg_write, jal, instr_done

Transitions:
- DECODE goes to: EXEC for opcode 0x00, MEMADR for 0x23 or 0x2B, BEQ for 0x04, JUMP for 0x02, JAL for 0x03.
- DECODE with any other opcode: illegal_op=1 and instr_done=1 in that cycle, then FETCH.
- MEMADR goes to MEMRD for lw and MEMWR for sw.
- MEMRD goes to MEMWB. EXEC goes to ALUWB.
- Every state with instr_done=1 goes to FETCH.
- Encodings 12-15 are unreachable; if ever entered, all outputs are 0 and the next state is FETCH.

Outputs are decoded combinationally from the state register only, so no output ever depends combinationally on opcode. The one exception is illegal_op/instr_done in DECODE, which do use opcode.

## Timing
- Reset: the state register clears to RST immediately, without waiting for a clock edge. All outputs are 0 while rst is high, and state=0.
- The first FETCH occurs on the first rising edge after rst is released.
- Latency in cycles, FETCH through the done cycle: lw 5, sw 4, R-type 4, beq 3, j 3, jal 3, illegal 2.
- Asserting rst mid-instruction abandons the instruction. Any write strobe already issued stays issued; no further strobes are issued.
- opcode is sampled only in DECODE and MEMADR. Changes to opcode in any other state have no effect.

## Configuration
- MC_MEM_READY_EN defined:
  - The mem_ready port exists.
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0, and keep mem_read/mem_write and i_or_d asserted during the wait.
  - In FETCH, pc_write and ir_write are ANDed with mem_ready, so the PC advances and the IR loads exactly once per fetch.
  - Each cycle mem_ready is low adds one cycle to the latency.
- MC_MEM_READY_EN undefined: the port is absent, memory is treated as always ready, and latencies are exactly those listed under Timing.

## Test plan
- Reset: hold rst high for 3 cycles with opcode=0x23 -> state=0 and all outputs 0. After release, the next cycle is FETCH with pc_write=1, ir_write=1 and alu_src_b=01.
- lw (opcode 0x23) -> state sequence 1,2,3,4,5. mem_read=1 with i_or_d=1 in state 4; reg_write=1 with mem_to_reg=1 in state 5; instr_done high only in state 5.
- sw (0x2B), then R-type (0x00), back to back -> states 1,2,3,6 then 1,2,7,8. mem_write is high for exactly 1 cycle; in state 8, reg_dst=1 and reg_write=1.
- Control flow: beq (0x04) -> 1,2,9 with pc_write_cond=1 and pc_src=01. jal (0x03) -> 1,2,11 with jal=1, reg_write=1, pc_write=1 and pc_src=10.
- Illegal opcode 0x3F -> illegal_op=1 and instr_done=1 for one cycle in DECODE, then FETCH. Separately, assert rst during state 4 -> state=0 asynchronously and mem_read drops to 0 in the same cycle.
- With MC_MEM_READY_EN and mem_ready held at 0 for 3 cycles in FETCH -> state stays 1, pc_write stays 0, and a single pc_write pulse occurs in the cycle where mem_ready=1.
